// File: rtl/chrono_counter_if.sv
// chrono_counter_if: control, preset and time-readout signals of the
// chrono_counter. The lap capture group exists only when CHRONO_LAP_EN is
// defined.
interface chrono_counter_if;
  logic       run;
  logic       dir;
  logic       load;
  logic [7:0] preset_sec;
  logic [7:0] preset_min;
  logic [7:0] preset_hour;
  logic [7:0] seconds;
  logic [7:0] minutes;
  logic [7:0] hours;
  logic       sec_tick;
  logic       expired;
`ifdef CHRONO_LAP_EN
  logic       lap;
  logic [7:0] lap_sec;
  logic [7:0] lap_min;
  logic [7:0] lap_hour;

  modport master (
    output run, dir, load, preset_sec, preset_min, preset_hour, lap,
    input  seconds, minutes, hours, sec_tick, expired, lap_sec, lap_min, lap_hour
  );
  modport slave (
    input  run, dir, load, preset_sec, preset_min, preset_hour, lap,
    output seconds, minutes, hours, sec_tick, expired, lap_sec, lap_min, lap_hour
  );
`else
  modport master (
    output run, dir, load, preset_sec, preset_min, preset_hour,
    input  seconds, minutes, hours, sec_tick, expired
  );
  modport slave (
    input  run, dir, load, preset_sec, preset_min, preset_hour,
    output seconds, minutes, hours, sec_tick, expired
  );
`endif
endinterface

// File: rtl/chrono_counter.sv
// chrono_counter: hh:mm:ss up/down counter with run/hold and a cycle
// prescaler. It has a clamped preset load, a one-cycle sec_tick per time
// advance, and an expired pulse when a down count reaches 00:00:00.
// Optional lap capture registers are built when CHRONO_LAP_EN is defined.
module chrono_counter #(
  parameter int TICKS_PER_SEC = 250,
  parameter int HOURS_MAX     = 99
) (
  input  logic             clock,
  input  logic             reset,
  chrono_counter_if.slave  bus
);

  localparam int         PW         = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [7:0] HMAX       = 8'(HOURS_MAX);
  localparam logic [7:0] LAST_MS    = 8'd59;

  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    sec_q, sec_d;
  logic [7:0]    min_q, min_d;
  logic [7:0]    hour_q, hour_d;
  logic          tick_q, tick_d;
  logic          exp_q, exp_d;

  logic at_zero;
  logic at_one;
  logic advance;

  assign at_zero = (sec_q == 8'd0) && (min_q == 8'd0) && (hour_q == 8'd0);
  assign at_one  = (sec_q == 8'd1) && (min_q == 8'd0) && (hour_q == 8'd0);

  // Prescaler and event decision. A down count parked at zero freezes the
  // prescaler at 0, so no advance can ever be issued from 00:00:00.
  always_comb begin
    presc_d = presc_q;
    advance = 1'b0;
    tick_d  = 1'b0;
    exp_d   = 1'b0;
    if (bus.load) begin
      presc_d = '0;
    end else if (bus.run) begin
      if (bus.dir && at_zero) begin
        presc_d = '0;
      end else if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        advance = 1'b1;
        tick_d  = 1'b1;
        exp_d   = bus.dir && at_one;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  // Time arithmetic: clamped preset on load, otherwise carry/borrow chain.
  // Up-count wraps use >= so a field can never step past its limit.
  always_comb begin
    sec_d  = sec_q;
    min_d  = min_q;
    hour_d = hour_q;
    if (bus.load) begin
      sec_d  = (bus.preset_sec  > LAST_MS) ? LAST_MS : bus.preset_sec;
      min_d  = (bus.preset_min  > LAST_MS) ? LAST_MS : bus.preset_min;
      hour_d = (bus.preset_hour > HMAX)    ? HMAX    : bus.preset_hour;
    end else if (advance && !bus.dir) begin
      if (sec_q >= LAST_MS) begin
        sec_d = 8'd0;
        if (min_q >= LAST_MS) begin
          min_d  = 8'd0;
          hour_d = (hour_q >= HMAX) ? 8'd0 : hour_q + 8'd1;
        end else begin
          min_d = min_q + 8'd1;
        end
      end else begin
        sec_d = sec_q + 8'd1;
      end
    end else if (advance) begin
      if (sec_q == 8'd0) begin
        sec_d = LAST_MS;
        if (min_q == 8'd0) begin
          min_d  = LAST_MS;
          hour_d = (hour_q == 8'd0) ? 8'd0 : hour_q - 8'd1;
        end else begin
          min_d = min_q - 8'd1;
        end
      end else begin
        sec_d = sec_q - 8'd1;
      end
    end
  end

  // Counter state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      sec_q   <= 8'd0;
      min_q   <= 8'd0;
      hour_q  <= 8'd0;
      tick_q  <= 1'b0;
      exp_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
      tick_q  <= tick_d;
      exp_q   <= exp_d;
    end
  end

  assign bus.seconds  = sec_q;
  assign bus.minutes  = min_q;
  assign bus.hours    = hour_q;
  assign bus.sec_tick = tick_q;
  assign bus.expired  = exp_q;

`ifdef CHRONO_LAP_EN
  logic [7:0] lap_sec_q, lap_sec_d;
  logic [7:0] lap_min_q, lap_min_d;
  logic [7:0] lap_hour_q, lap_hour_d;

  // Lap capture takes the pre-edge time, even when load or an advance
  // happens on the same edge.
  always_comb begin
    lap_sec_d  = lap_sec_q;
    lap_min_d  = lap_min_q;
    lap_hour_d = lap_hour_q;
    if (bus.lap) begin
      lap_sec_d  = sec_q;
      lap_min_d  = min_q;
      lap_hour_d = hour_q;
    end
  end

  // Lap registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lap_sec_q  <= 8'd0;
      lap_min_q  <= 8'd0;
      lap_hour_q <= 8'd0;
    end else begin
      lap_sec_q  <= lap_sec_d;
      lap_min_q  <= lap_min_d;
      lap_hour_q <= lap_hour_d;
    end
  end

  assign bus.lap_sec  = lap_sec_q;
  assign bus.lap_min  = lap_min_q;
  assign bus.lap_hour = lap_hour_q;
`endif

endmodule

// File: doc/chrono_counter.md
CHRONO_COUNTER -- requirements
Module: chrono_counter

Interface
REQ-001 The block SHALL have parameter TICKS_PER_SEC, default 250, meaning clock cycles per counted second (2..2^25-1).
REQ-002 The block SHALL have parameter HOURS_MAX, default 99, meaning the highest hours value (1..255).
REQ-003 The block SHALL have port clock  in  1  sole clock, all state on rising edge.
REQ-004 The block SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port run  in  1  level; counting enabled while high.
REQ-006 The block SHALL have port dir  in  1  0 = count up, 1 = count down.
REQ-007 The block SHALL have port load  in  1  synchronous preset load strobe.
REQ-008 The block SHALL have ports preset_sec, preset_min, preset_hour  in  8 each  load values.
REQ-009 The block SHALL have ports seconds, minutes, hours  out  8 each  registered binary time.
REQ-010 The block SHALL have port sec_tick  out  1  one-cycle pulse per time advance.
REQ-011 The block SHALL have port expired  out  1  one-cycle pulse on down-count reaching 00:00:00.
REQ-012 With CHRONO_LAP_EN, the block SHALL have port lap  in  1  capture strobe, and lap_sec, lap_min, lap_hour  out  8 each  captured time.

Function
REQ-013 The prescaler SHALL count 0..TICKS_PER_SEC-1 only on edges with run=1; with run=0 the prescaler and time SHALL hold.
REQ-014 On an edge with run=1 and prescaler=TICKS_PER_SEC-1, the prescaler SHALL wrap to 0 and time SHALL advance one second on that same edge.
REQ-015 sec_tick SHALL be registered, high exactly in the cycle after each time advance, otherwise low.
REQ-016 Up count: seconds 59->0 with carry; minutes 59->0 with carry; hours HOURS_MAX->0, i.e. HOURS_MAX:59:59 wraps to 00:00:00.
REQ-017 Down count: seconds 0->59 with borrow; minutes 0->59 with borrow into hours.
REQ-018 Down count at 00:00:00 SHALL hold time at zero, keep the prescaler at 0, and produce no sec_tick.
REQ-019 expired SHALL pulse high for one cycle, coincident with sec_tick, only on the 00:00:01->00:00:00 down transition.
REQ-020 Changing dir mid-second SHALL NOT reset the prescaler; the next advance uses the new direction.
REQ-021 load=1 SHALL take priority over counting: time <= preset, prescaler <= 0, sec_tick and expired low next cycle.
REQ-022 Preset values SHALL be clamped on load: seconds and minutes >59 -> 59; hours >HOURS_MAX -> HOURS_MAX.
REQ-023 Internal arithmetic SHALL never produce seconds or minutes >59 or hours >HOURS_MAX.

Reset
REQ-024 reset=1 SHALL immediately, without a clock edge, force prescaler, seconds, minutes, hours, sec_tick, expired and lap registers to 0.
REQ-025 Reset asserted mid-second SHALL discard the partial prescaler count; counting resumes from 0 on the first edge after release.

Configuration
REQ-026 With CHRONO_LAP_EN defined, an edge with lap=1 SHALL copy the pre-edge seconds/minutes/hours into lap_sec/lap_min/lap_hour, which hold until the next lap or reset.
REQ-027 A lap coincident with load or a time advance SHALL capture the pre-edge (old) time.
REQ-028 Without CHRONO_LAP_EN, lap, lap_sec, lap_min and lap_hour SHALL be absent, with no lap registers.

Verification
REQ-029 Release reset; run=1, dir=0 for 250 edges -> seconds=1 after the 250th edge, sec_tick high one cycle, minutes=hours=0.
REQ-030 Load 00:59:59, run up one second -> 01:00:00. Load 99:59:59, run up one second -> 00:00:00.
REQ-031 Load 00:00:02, dir=1, run -> 00:00:01, then 00:00:00 with one expired pulse; 1000 further cycles -> time 0, no sec_tick, no expired.
REQ-032 Load preset 75/80/200 -> seconds=59, minutes=59, hours=99. Run 100 cycles, drop run 100 cycles, raise run -> next advance after 150 more run-high edges.
REQ-033 Assert reset between clock edges mid-count -> all outputs 0 before the next edge; no sec_tick on release.
REQ-034 With CHRONO_LAP_EN: at 00:00:05 pulse lap on the advancing edge -> lap = 00:00:05 while time = 00:00:06; lap holds through the following 3 seconds.
